// File: rtl/pipelined_operand_mux.sv
// rtl/pipelined_operand_mux.sv - registered N-way operand select with stall, flush and select-error tracking
module pipelined_operand_mux #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    sel_err,
  output logic [7:0]              err_count
);

  logic [31:0]      sel_ext;
  logic             sel_oor;
  logic [WIDTH-1:0] sel_data;

  assign sel_ext = 32'(sel);
  // Only reachable when NUM_IN is not a power of two.
  assign sel_oor = (sel_ext >= 32'(NUM_IN));

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_ext == 32'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      err_count <= 8'h00;
    end else if (flush) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else if (!stall) begin
      if (in_valid && !sel_oor) begin
        out_data  <= sel_data;
        out_valid <= 1'b1;
        sel_err   <= 1'b0;
      end else if (in_valid) begin
        out_data  <= '0;
        out_valid <= 1'b1;
        sel_err   <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'h01;
      end else begin
        out_data  <= '0;
        out_valid <= 1'b0;
        sel_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_operand_mux.sv
// tb/tb_pipelined_operand_mux.sv - directed bench over default, 3-input and 32x8 configurations
module tb_pipelined_operand_mux;

  logic clk = 1'b0;
  logic reset_n, in_valid, stall, flush;

  logic [255:0] d_data;
  logic [1:0]   d_sel;
  logic [63:0]  d_out;
  logic         d_valid, d_err;
  logic [7:0]   d_cnt;

  logic [191:0] t_data;
  logic [1:0]   t_sel;
  logic [63:0]  t_out;
  logic         t_valid, t_err;
  logic [7:0]   t_cnt;

  logic [255:0] w_data;
  logic [2:0]   w_sel;
  logic [31:0]  w_out;
  logic         w_valid, w_err;
  logic [7:0]   w_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_operand_mux u_def (
    .clk(clk), .reset_n(reset_n), .in_data(d_data), .sel(d_sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(d_out), .out_valid(d_valid),
    .sel_err(d_err), .err_count(d_cnt)
  );

  pipelined_operand_mux #(.WIDTH(64), .NUM_IN(3), .SEL_W(2)) u_n3 (
    .clk(clk), .reset_n(reset_n), .in_data(t_data), .sel(t_sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(t_out), .out_valid(t_valid),
    .sel_err(t_err), .err_count(t_cnt)
  );

  pipelined_operand_mux #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) u_w32 (
    .clk(clk), .reset_n(reset_n), .in_data(w_data), .sel(w_sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(w_out), .out_valid(w_valid),
    .sel_err(w_err), .err_count(w_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    d_sel = '0; t_sel = '0; w_sel = '0;
    for (int k = 0; k < 4; k++) d_data[k*64 +: 64] = 64'h1000 + 64'(k);
    for (int k = 0; k < 3; k++) t_data[k*64 +: 64] = 64'hABC0_0000_0000_0000 + 64'(k);
    for (int k = 0; k < 8; k++) w_data[k*32 +: 32] = 32'hC0DE_0000 + 32'(k) * 32'h0101_0011;
    step();
    check("rst_d_out", d_out, 64'h0);
    check("rst_d_valid", {63'h0, d_valid}, 64'h0);
    check("rst_t_err", {63'h0, t_err}, 64'h0);
    check("rst_t_cnt", {56'h0, t_cnt}, 64'h0);
    check("rst_w_out", {32'h0, w_out}, 64'h0);
    reset_n = 1'b1;

    // default config: straight sweep
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d_sel = 2'(k);
      step();
      check($sformatf("sweep_out%0d", k), d_out, 64'h1000 + 64'(k));
      check($sformatf("sweep_valid%0d", k), {63'h0, d_valid}, 64'h1);
      check($sformatf("sweep_err%0d", k), {63'h0, d_err}, 64'h0);
    end

    // 3-input config: out-of-range selects
    t_sel = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("oor_out%0d", i), t_out, 64'h0);
      check($sformatf("oor_valid%0d", i), {63'h0, t_valid}, 64'h1);
      check($sformatf("oor_err%0d", i), {63'h0, t_err}, 64'h1);
      check($sformatf("oor_cnt%0d", i), {56'h0, t_cnt}, 64'(i));
    end
    in_valid = 1'b0;
    step();
    check("inv_cnt", {56'h0, t_cnt}, 64'h3);
    check("inv_valid", {63'h0, t_valid}, 64'h0);
    check("inv_err", {63'h0, t_err}, 64'h0);
    check("inv_out", t_out, 64'h0);

    // flush with an out-of-range select must not count
    in_valid = 1'b1; flush = 1'b1;
    step();
    check("flush_cnt", {56'h0, t_cnt}, 64'h3);
    check("flush_t_valid", {63'h0, t_valid}, 64'h0);
    flush = 1'b0;

    // stall hold then flush overriding stall
    d_data[64 +: 64] = 64'hDEAD;
    d_sel = 2'd1;
    step();
    check("dead_load", d_out, 64'hDEAD);
    check("oor_after_flush_cnt", {56'h0, t_cnt}, 64'h4);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_sel = 2'(i);
      step();
      check($sformatf("stall_out%0d", i), d_out, 64'hDEAD);
      check($sformatf("stall_valid%0d", i), {63'h0, d_valid}, 64'h1);
      check($sformatf("stall_cnt%0d", i), {56'h0, t_cnt}, 64'h4);
    end
    flush = 1'b1;
    step();
    check("sf_out", d_out, 64'h0);
    check("sf_valid", {63'h0, d_valid}, 64'h0);
    stall = 1'b0; flush = 1'b0;

    // async reset between edges
    step();
    check("pre_rst_cnt", {56'h0, t_cnt}, 64'h5);
    check("pre_rst_valid", {63'h0, t_valid}, 64'h1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out", t_out, 64'h0);
    check("arst_valid", {63'h0, t_valid}, 64'h0);
    check("arst_err", {63'h0, t_err}, 64'h0);
    check("arst_cnt", {56'h0, t_cnt}, 64'h0);
    #1 reset_n = 1'b1;
    t_sel = 2'd0;
    step();
    check("post_rst_out", t_out, 64'hABC0_0000_0000_0000);
    check("post_rst_valid", {63'h0, t_valid}, 64'h1);

    // saturation, with a stall window that must not count
    t_sel = 2'b11;
    for (int i = 1; i <= 300; i++) begin
      step();
      check($sformatf("sat_cnt%0d", i), {56'h0, t_cnt}, (i > 255) ? 64'hFF : 64'(i));
      if (i == 10) begin
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
          step();
          check($sformatf("sat_stall%0d", j), {56'h0, t_cnt}, 64'd10);
        end
        stall = 1'b0;
      end
    end
    check("sat_err", {63'h0, t_err}, 64'h1);

    // 32-bit, 8-input sweep
    for (int k = 0; k < 8; k++) begin
      w_sel = 3'(k);
      step();
      check($sformatf("w32_out%0d", k), {32'h0, w_out}, {32'h0, 32'hC0DE_0000 + 32'(k) * 32'h0101_0011});
      check($sformatf("w32_err%0d", k), {63'h0, w_err}, 64'h0);
    end
    check("w32_cnt", {56'h0, w_cnt}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
